// File: rtl/retire_map.sv
// -----------------------------------------------------------------------------
// retire_map
//
// Retirement rename table (RRAT) and physical-register release stage. Sits
// directly behind the ROB commit port.
//   * Holds the committed architectural -> physical mapping (rrat[0..31]).
//   * Pushes each superseded physical tag into a small release FIFO that the
//     free list drains through a valid/ready handshake.
//   * On a mispredict, streams the committed mapping back to the speculative
//     rename map, one architectural register per cycle (x0..x31), then pulses
//     recover_done.
//   * Offers a combinational debug read port into the table.
//
// Ports
//   clk, reset         clock; synchronous active-low reset
//   commit_*           ROB commit handshake (valid/ready) and payload
//   free_valid/ready   release handshake, free_pr is the head tag
//   recover_req        one-cycle mispredict recovery request
//   recover_busy       restore stream in progress (registered)
//   restore_*          restore stream entry (registered)
//   recover_done       one-cycle pulse after the last restore entry
//   dbg_arch/dbg_pr    combinational debug read of rrat[dbg_arch]
// -----------------------------------------------------------------------------
module retire_map #(
  parameter int PR_W       = 7,
  parameter int FREE_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            commit_valid,
  output logic            commit_ready,
  input  logic            commit_has_rd,
  input  logic [4:0]      commit_rd,
  input  logic [PR_W-1:0] commit_pd_new,
  input  logic [PR_W-1:0] commit_pd_old,

  output logic            free_valid,
  input  logic            free_ready,
  output logic [PR_W-1:0] free_pr,

  input  logic            recover_req,
  output logic            recover_busy,
  output logic            restore_valid,
  output logic [4:0]      restore_arch,
  output logic [PR_W-1:0] restore_pr,
  output logic            recover_done,

  input  logic [4:0]      dbg_arch,
  output logic [PR_W-1:0] dbg_pr
);

  localparam int PTR_W = (FREE_DEPTH > 1) ? $clog2(FREE_DEPTH) : 1;
  localparam int CNT_W = $clog2(FREE_DEPTH) + 1;

  typedef enum logic {
    IDLE    = 1'b0,
    RESTORE = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [4:0]      idx, idx_nxt;
  logic            restore_valid_nxt;
  logic [4:0]      restore_arch_nxt;
  logic [PR_W-1:0] restore_pr_nxt;
  logic            recover_done_nxt;

  logic [PR_W-1:0] rrat [32];

  logic [PR_W-1:0] fifo_mem [FREE_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic commit_fire;
  logic table_write;
  logic push;
  logic pop;

  // ---------------------------------------------------------------------------
  // Handshakes. commit_ready looks at the count before any pop this cycle, so a
  // full FIFO never accepts a push even while it is being drained.
  // ---------------------------------------------------------------------------
  assign commit_ready = (state == IDLE) && (count < CNT_W'(FREE_DEPTH));
  assign commit_fire  = commit_valid && commit_ready;
  // x0 is hardwired: it is never remapped and never releases a tag.
  assign table_write  = commit_fire && commit_has_rd && (commit_rd != 5'd0);
  assign push         = table_write;

  assign free_valid   = (count != '0);
  // The FIFO storage has no reset, so gate the head with valid to keep
  // free_pr at a defined zero whenever nothing is queued.
  assign free_pr      = free_valid ? fifo_mem[rd_ptr] : '0;
  assign pop          = free_valid && free_ready;

  assign dbg_pr       = rrat[dbg_arch];
  assign recover_busy = (state == RESTORE);

  // ---------------------------------------------------------------------------
  // Retirement rename table
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rrat[i] <= PR_W'(i);
    end else if (table_write) begin
      rrat[commit_rd] <= commit_pd_new;
    end
  end

  // ---------------------------------------------------------------------------
  // Release FIFO
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is deliberately not reset; only pointers and count
  // are. Entries are only ever read while count says they were written.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= commit_pd_old;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because FREE_DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Recovery FSM. The restore outputs are registered, so the next-state logic
  // also computes the entry that will be visible in the following cycle:
  // entry 0 is loaded on the recover_req edge, entry idx+1 on each RESTORE
  // edge, and the edge after entry 31 returns to IDLE and raises done.
  // Commits are blocked during RESTORE, so rrat is stable while streaming; a
  // commit accepted alongside recover_req lands in rrat before entry 1 is read.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      idx           <= '0;
      restore_valid <= 1'b0;
      restore_arch  <= '0;
      restore_pr    <= '0;
      recover_done  <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      restore_valid <= restore_valid_nxt;
      restore_arch  <= restore_arch_nxt;
      restore_pr    <= restore_pr_nxt;
      recover_done  <= recover_done_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through the
  // case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt         = state;
    idx_nxt           = idx;
    restore_valid_nxt = 1'b0;
    restore_arch_nxt  = '0;
    restore_pr_nxt    = '0;
    recover_done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (recover_req) begin
          state_nxt         = RESTORE;
          idx_nxt           = '0;
          restore_valid_nxt = 1'b1;
          restore_arch_nxt  = '0;
          restore_pr_nxt    = '0;  // x0 always restores to p0
        end
      end
      RESTORE: begin
        if (idx == 5'd31) begin
          state_nxt        = IDLE;
          idx_nxt          = '0;
          recover_done_nxt = 1'b1;
        end else begin
          idx_nxt           = idx + 5'd1;
          restore_valid_nxt = 1'b1;
          restore_arch_nxt  = idx + 5'd1;
          restore_pr_nxt    = rrat[idx + 5'd1];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_retire_map.sv
// -----------------------------------------------------------------------------
// tb_retire_map
//
// Directed bench for retire_map: reset state and debug sweep, single commit
// with immediate release, FIFO full backpressure and drain order, x0 and
// no-rd commits, a full recovery stream with a same-cycle commit, and reset
// aborting a recovery in flight.
// Inputs are driven 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_retire_map;

  localparam int PR_W       = 7;
  localparam int FREE_DEPTH = 4;

  logic            clk;
  logic            reset;
  logic            commit_valid;
  logic            commit_ready;
  logic            commit_has_rd;
  logic [4:0]      commit_rd;
  logic [PR_W-1:0] commit_pd_new;
  logic [PR_W-1:0] commit_pd_old;
  logic            free_valid;
  logic            free_ready;
  logic [PR_W-1:0] free_pr;
  logic            recover_req;
  logic            recover_busy;
  logic            restore_valid;
  logic [4:0]      restore_arch;
  logic [PR_W-1:0] restore_pr;
  logic            recover_done;
  logic [4:0]      dbg_arch;
  logic [PR_W-1:0] dbg_pr;

  int vectors = 0;
  int errors  = 0;

  // Expected committed mapping, maintained by hand alongside the stimulus.
  logic [PR_W-1:0] exp_rrat [32];

  retire_map #(.PR_W(PR_W), .FREE_DEPTH(FREE_DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .commit_valid  (commit_valid),
    .commit_ready  (commit_ready),
    .commit_has_rd (commit_has_rd),
    .commit_rd     (commit_rd),
    .commit_pd_new (commit_pd_new),
    .commit_pd_old (commit_pd_old),
    .free_valid    (free_valid),
    .free_ready    (free_ready),
    .free_pr       (free_pr),
    .recover_req   (recover_req),
    .recover_busy  (recover_busy),
    .restore_valid (restore_valid),
    .restore_arch  (restore_arch),
    .restore_pr    (restore_pr),
    .recover_done  (recover_done),
    .dbg_arch      (dbg_arch),
    .dbg_pr        (dbg_pr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " commit_ready"},  32'(commit_ready),  32'd1);
    check({tag, " free_valid"},    32'(free_valid),    32'd0);
    check({tag, " free_pr"},       32'(free_pr),       32'd0);
    check({tag, " recover_busy"},  32'(recover_busy),  32'd0);
    check({tag, " restore_valid"}, 32'(restore_valid), 32'd0);
    check({tag, " restore_arch"},  32'(restore_arch),  32'd0);
    check({tag, " restore_pr"},    32'(restore_pr),    32'd0);
    check({tag, " recover_done"},  32'(recover_done),  32'd0);
  endtask

  task automatic set_commit(input logic v, input logic has_rd, input int rd,
                            input int pd_new, input int pd_old);
    commit_valid  = v;
    commit_has_rd = has_rd;
    commit_rd     = 5'(rd);
    commit_pd_new = PR_W'(pd_new);
    commit_pd_old = PR_W'(pd_old);
  endtask

  initial begin
    logic done_seen;

    reset       = 1'b0;
    set_commit(1'b0, 1'b0, 0, 0, 0);
    free_ready  = 1'b0;
    recover_req = 1'b0;
    dbg_arch    = '0;
    for (int i = 0; i < 32; i++) exp_rrat[i] = PR_W'(i);

    // ---------------- Reset and identity sweep ----------------
    tick();
    tick();
    reset = 1'b1;
    check_reset_outputs("reset");
    for (int i = 0; i < 32; i++) begin
      dbg_arch = 5'(i);
      #1;
      check($sformatf("dbg identity x%0d", i), 32'(dbg_pr), 32'(i));
    end
    tick();

    // ---------------- Single commit, released immediately ----------------
    set_commit(1'b1, 1'b1, 10, 40, 10);
    free_ready = 1'b1;
    dbg_arch   = 5'd10;
    check("c1 ready", 32'(commit_ready), 32'd1);
    tick();
    set_commit(1'b0, 1'b0, 0, 0, 0);
    exp_rrat[10] = 7'd40;
    check("c1 dbg x10",     32'(dbg_pr),     32'd40);
    check("c1 free_valid",  32'(free_valid), 32'd1);
    check("c1 free_pr",     32'(free_pr),    32'd10);
    tick();
    check("c1 drained",     32'(free_valid), 32'd0);

    // ---------------- Fill FIFO with free_ready low ----------------
    free_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_commit(1'b1, 1'b1, 5 + k, 50 + k, 5 + k);
      check($sformatf("fill ready %0d", k), 32'(commit_ready), 32'd1);
      tick();
      exp_rrat[5 + k] = PR_W'(50 + k);
    end
    set_commit(1'b1, 1'b1, 9, 54, 9);
    check("full ready low",   32'(commit_ready), 32'd0);
    check("full head",        32'(free_pr),      32'd5);
    tick();
    check("full still low",   32'(commit_ready), 32'd0);
    free_ready = 1'b1;
    #1;
    check("pop cycle ready",  32'(commit_ready), 32'd0);
    tick();
    check("after pop ready",  32'(commit_ready), 32'd1);
    check("drain 6",          32'(free_pr),      32'd6);
    tick();
    exp_rrat[9] = 7'd54;
    set_commit(1'b0, 1'b0, 0, 0, 0);
    check("drain 7",          32'(free_pr),      32'd7);
    tick();
    check("drain 8",          32'(free_pr),      32'd8);
    tick();
    check("drain 9",          32'(free_pr),      32'd9);
    tick();
    check("drain empty",      32'(free_valid),   32'd0);
    dbg_arch = 5'd9;
    #1;
    check("dbg x9",           32'(dbg_pr),       32'd54);
    dbg_arch = 5'd5;
    #1;
    check("dbg x5",           32'(dbg_pr),       32'd50);

    // ---------------- x0 and no-rd commits ----------------
    free_ready = 1'b0;
    tick();
    set_commit(1'b1, 1'b1, 0, 99, 77);
    tick();
    set_commit(1'b1, 1'b0, 3, 33, 3);
    dbg_arch = 5'd0;
    #1;
    check("x0 no push",       32'(free_valid),   32'd0);
    check("x0 stays p0",      32'(dbg_pr),       32'd0);
    tick();
    set_commit(1'b0, 1'b0, 0, 0, 0);
    dbg_arch = 5'd3;
    #1;
    check("no-rd no push",    32'(free_valid),   32'd0);
    check("no-rd x3 kept",    32'(dbg_pr),       32'd3);

    // ---------------- Recovery with same-cycle commit ----------------
    tick();
    set_commit(1'b1, 1'b1, 28, 70, 28);
    recover_req = 1'b1;
    free_ready  = 1'b1;
    check("rec commit ready", 32'(commit_ready), 32'd1);
    tick();                                   // edge T
    set_commit(1'b0, 1'b0, 0, 0, 0);
    recover_req  = 1'b0;
    exp_rrat[28] = 7'd70;
    check("rec released 28",  32'(free_pr),      32'd28);
    check("rec free_valid",   32'(free_valid),   32'd1);
    for (int i = 0; i < 32; i++) begin
      // A late commit to x4 and a repeated recover_req must both be ignored.
      if (i == 2) set_commit(1'b1, 1'b1, 4, 88, 4);
      if (i == 3) set_commit(1'b0, 1'b0, 0, 0, 0);
      recover_req = (i == 5);
      #1;
      check($sformatf("rst valid %0d", i), 32'(restore_valid), 32'd1);
      check($sformatf("rst arch %0d", i),  32'(restore_arch),  32'(i));
      check($sformatf("rst pr %0d", i),    32'(restore_pr),    32'(exp_rrat[i]));
      check($sformatf("rst busy %0d", i),  32'(recover_busy),  32'd1);
      check($sformatf("rst cready %0d", i), 32'(commit_ready), 32'd0);
      check($sformatf("rst done %0d", i),  32'(recover_done),  32'd0);
      tick();
    end
    recover_req = 1'b0;
    check("done pulse",       32'(recover_done),  32'd1);
    check("done valid low",   32'(restore_valid), 32'd0);
    check("done busy low",    32'(recover_busy),  32'd0);
    check("done cready",      32'(commit_ready),  32'd1);
    check("fifo empty",       32'(free_valid),    32'd0);
    tick();
    check("done one cycle",   32'(recover_done),  32'd0);
    check("no second stream", 32'(restore_valid), 32'd0);

    // ---------------- Reset in the middle of recovery ----------------
    recover_req = 1'b1;
    tick();
    recover_req = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("abort at arch 12", 32'(restore_arch),  32'd12);
    check("abort pr 12",      32'(restore_pr),    32'd12);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_reset_outputs("abort");
    dbg_arch = 5'd10;
    #1;
    check("abort x10 ident",  32'(dbg_pr),        32'd10);
    dbg_arch = 5'd28;
    #1;
    check("abort x28 ident",  32'(dbg_pr),        32'd28);
    dbg_arch = 5'd7;
    #1;
    check("abort x7 ident",   32'(dbg_pr),        32'd7);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      done_seen = done_seen | recover_done | restore_valid;
    end
    check("abort no done",    32'(done_seen),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
